// File: rtl/term_seq_pkg.sv
// Shared types and constants for the sequential event counter.
// Holds the controller states, the mode encodings and the channel-index width helper.
package term_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Channel index width; a single channel still needs a one-bit index port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/term_seq_chan.sv
// One event counter with a sticky wrap/saturate flag.
// cnt_next is the value the counter takes on the next edge, unless a clear overrides it.
module term_seq_chan #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap,
  output logic             flag
);

  logic [WIDTH-1:0] cnt_reg;
  logic             flag_reg;
  logic             at_max;

  always_comb begin
    at_max   = &cnt_reg;
    wrap     = inc & at_max;
    cnt_next = cnt_reg;
    if (inc) begin
      if (at_max) begin
        cnt_next = sat_mode ? cnt_reg : '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (wrap) begin
        flag_reg <= 1'b1;
      end
    end
  end

  assign flag = flag_reg;

endmodule

// File: rtl/term_seq_counter.sv
// Multi-channel qualified event counter behind valid/ready streams.
// Every accepted event yields one registered result beat on the following cycle.
module term_seq_counter
  import term_seq_pkg::*;
#(
  parameter int  WIDTH    = 5,
  parameter int  CHANNELS = 4,
  parameter int  LANES    = 5,
  parameter int  SAT_MODE = MODE_WRAP,
  localparam int CW       = ch_width(CHANNELS)
) (
  input  logic                clk_pad,
  input  logic                rst_pad,
  input  logic                en_pad,
  input  logic                clr_pad,
  input  logic                in_valid_pad,
  output logic                in_ready_pad,
  input  logic [CW-1:0]       in_ch_pad,
  input  logic [LANES-1:0]    lane_a_pad,
  input  logic [LANES-1:0]    lane_b_pad,
  output logic                out_valid_pad,
  input  logic                out_ready_pad,
  output logic [CW-1:0]       out_ch_pad,
  output logic [WIDTH-1:0]    out_cnt_pad,
  output logic                out_hit_pad,
  output logic                out_wrap_pad,
  output logic                out_par_pad,
  output logic [CHANNELS-1:0] wrap_flags_pad,
  output logic                busy_pad
);

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] cnt;
    logic             hit;
    logic             wrap;
    logic             par;
  } beat_t;

  localparam logic SAT_BIT = (SAT_MODE == MODE_SAT);

  state_t state_reg, state_next;
  beat_t  beat_reg, beat_next;
  logic   out_valid_reg;

  logic qual, in_range, accept, in_ready;
  logic [CHANNELS-1:0] inc_vec, wrap_vec, flag_vec;
  logic [WIDTH-1:0]    cnt_nxt [CHANNELS];
  logic [WIDTH-1:0]    sel_cnt;
  logic                sel_wrap;

  assign qual     = &(lane_a_pad | lane_b_pad);
  assign in_range = (int'(in_ch_pad) < CHANNELS);
  // A new beat may enter whenever the output register is empty or being emptied this cycle.
  assign in_ready = (state_reg == ACTIVE) & en_pad & ~clr_pad & (~out_valid_reg | out_ready_pad);
  assign accept   = in_valid_pad & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign inc_vec[gi] = accept & qual & (int'(in_ch_pad) == gi);

      term_seq_chan #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk      (clk_pad),
        .rst      (rst_pad),
        .inc      (inc_vec[gi]),
        .clr      (clr_pad),
        .sat_mode (SAT_BIT),
        .cnt_next (cnt_nxt[gi]),
        .wrap     (wrap_vec[gi]),
        .flag     (flag_vec[gi])
      );
    end
  endgenerate

  // Out-of-range channels select nothing, so their beat reports a zero count.
  always_comb begin
    sel_cnt  = '0;
    sel_wrap = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(in_ch_pad) == i) begin
        sel_cnt  = cnt_nxt[i];
        sel_wrap = wrap_vec[i];
      end
    end
  end

  always_comb begin
    beat_next      = '0;
    beat_next.ch   = in_ch_pad;
    beat_next.cnt  = sel_cnt;
    beat_next.hit  = qual & in_range;
    beat_next.wrap = sel_wrap;
    beat_next.par  = ^sel_cnt;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (en_pad) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!en_pad) begin
          state_next = out_valid_reg ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (en_pad) begin
          state_next = ACTIVE;
        end else if (!out_valid_reg || out_ready_pad) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      out_valid_reg <= 1'b0;
      beat_reg      <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      beat_reg      <= beat_next;
    end else if (out_ready_pad) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign in_ready_pad   = in_ready;
  assign out_valid_pad  = out_valid_reg;
  assign out_ch_pad     = beat_reg.ch;
  assign out_cnt_pad    = beat_reg.cnt;
  assign out_hit_pad    = beat_reg.hit;
  assign out_wrap_pad   = beat_reg.wrap;
  assign out_par_pad    = beat_reg.par;
  assign wrap_flags_pad = flag_vec;
  assign busy_pad       = (state_reg != IDLE);

endmodule

// File: tb/tb_term_seq_counter.sv
// Scoreboard bench for term_seq_counter: a wrap-mode and a saturate-mode instance share stimulus,
// each checked against its own arithmetic reference model.
module tb_term_seq_counter;

  localparam int W    = 5;
  localparam int CH   = 3;
  localparam int L    = 5;
  localparam int CW   = 2;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int ch;
    int cnt;
    int hit;
    int wrap;
    int par;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, clr, in_valid, out_ready;
  logic [CW-1:0] in_ch;
  logic [L-1:0]  lane_a, lane_b;

  logic          ir0, ov0, hit0, wr0, par0, busy0;
  logic [CW-1:0] och0;
  logic [W-1:0]  ocnt0;
  logic [CH-1:0] wf0;
  logic          ir1, ov1, hit1, wr1, par1, busy1;
  logic [CW-1:0] och1;
  logic [W-1:0]  ocnt1;
  logic [CH-1:0] wf1;

  term_seq_counter #(.WIDTH(W), .CHANNELS(CH), .LANES(L), .SAT_MODE(0)) dut_wrap (
    .clk_pad(clk), .rst_pad(rst), .en_pad(en), .clr_pad(clr),
    .in_valid_pad(in_valid), .in_ready_pad(ir0), .in_ch_pad(in_ch),
    .lane_a_pad(lane_a), .lane_b_pad(lane_b),
    .out_valid_pad(ov0), .out_ready_pad(out_ready), .out_ch_pad(och0),
    .out_cnt_pad(ocnt0), .out_hit_pad(hit0), .out_wrap_pad(wr0), .out_par_pad(par0),
    .wrap_flags_pad(wf0), .busy_pad(busy0)
  );

  term_seq_counter #(.WIDTH(W), .CHANNELS(CH), .LANES(L), .SAT_MODE(1)) dut_sat (
    .clk_pad(clk), .rst_pad(rst), .en_pad(en), .clr_pad(clr),
    .in_valid_pad(in_valid), .in_ready_pad(ir1), .in_ch_pad(in_ch),
    .lane_a_pad(lane_a), .lane_b_pad(lane_b),
    .out_valid_pad(ov1), .out_ready_pad(out_ready), .out_ch_pad(och1),
    .out_cnt_pad(ocnt1), .out_hit_pad(hit1), .out_wrap_pad(wr1), .out_par_pad(par1),
    .wrap_flags_pad(wf1), .busy_pad(busy1)
  );

  // Reference state: index 0 models the wrap instance, index 1 the saturate instance.
  int            mcnt  [2][CH];
  logic [CH-1:0] mflags[2];
  beat_t         exp_q [2][$];
  int            n_pass  = 0;
  int            n_total = 0;

  task automatic chk(input string nm, input int d, input longint got, input longint want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s dut%0d: got %0d want %0d", nm, d, got, want);
  endtask

  function automatic int par_of(input int v);
    int p = 0;
    for (int i = 0; i < W; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) mcnt[d][c] = 0;
      mflags[d] = '0;
      exp_q[d].delete();
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) mcnt[d][c] = 0;
      mflags[d] = '0;
    end
  endtask

  task automatic model_accept(input int d);
    beat_t b;
    bit    qual;
    qual   = ((lane_a | lane_b) == {L{1'b1}});
    b.ch   = int'(in_ch);
    b.cnt  = 0;
    b.hit  = 0;
    b.wrap = 0;
    if (int'(in_ch) < CH) begin
      b.cnt = mcnt[d][in_ch];
      if (qual) begin
        b.hit = 1;
        if (b.cnt == MAXV) begin
          b.wrap = 1;
          b.cnt  = (d == 1) ? MAXV : 0;
          mflags[d][in_ch] = 1'b1;
        end else begin
          b.cnt = b.cnt + 1;
        end
        mcnt[d][in_ch] = b.cnt;
      end
    end
    b.par = par_of(b.cnt);
    exp_q[d].push_back(b);
  endtask

  task automatic mon(input int d, input logic ov, input logic [CW-1:0] och, input logic [W-1:0] ocnt,
                     input logic hit, input logic wr, input logic par, input logic [CH-1:0] wf);
    chk("wrap_flags", d, wf, mflags[d]);
    if (ov) begin
      if (exp_q[d].size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat dut%0d: got beat ch=%0d cnt=%0d want no beat", d, och, ocnt);
      end else begin
        beat_t b;
        b = exp_q[d][0];
        chk("out_ch",   d, och,  b.ch);
        chk("out_cnt",  d, ocnt, b.cnt);
        chk("out_hit",  d, hit,  b.hit);
        chk("out_wrap", d, wr,   b.wrap);
        chk("out_par",  d, par,  b.par);
        if (out_ready) void'(exp_q[d].pop_front());
      end
    end
  endtask

  // Monitor: samples 3 ns after the falling edge, ahead of the stimulus bookkeeping at +4.
  always begin
    @(negedge clk);
    #3;
    mon(0, ov0, och0, ocnt0, hit0, wr0, par0, wf0);
    mon(1, ov1, och1, ocnt1, hit1, wr1, par1, wf1);
  end

  // One clock of stimulus; inputs were set at the falling edge. want_ready < 0 skips the ready check.
  task automatic step(input int want_ready);
    #4;
    if (want_ready >= 0) begin
      chk("in_ready", 0, ir0, want_ready);
      chk("in_ready", 1, ir1, want_ready);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (in_valid && ir0) model_accept(0);
      if (in_valid && ir1) model_accept(1);
      if (clr) model_clear();
    end
    @(negedge clk);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_valid"}, 0, ov0, 0);    chk({tag, "_valid"}, 1, ov1, 0);
    chk({tag, "_busy"},  0, busy0, 0);  chk({tag, "_busy"},  1, busy1, 0);
    chk({tag, "_ready"}, 0, ir0, 0);    chk({tag, "_ready"}, 1, ir1, 0);
    chk({tag, "_cnt"},   0, ocnt0, 0);  chk({tag, "_cnt"},   1, ocnt1, 0);
    chk({tag, "_ch"},    0, och0, 0);   chk({tag, "_ch"},    1, och1, 0);
    chk({tag, "_hit"},   0, hit0, 0);   chk({tag, "_hit"},   1, hit1, 0);
    chk({tag, "_wrap"},  0, wr0, 0);    chk({tag, "_wrap"},  1, wr1, 0);
    chk({tag, "_par"},   0, par0, 0);   chk({tag, "_par"},   1, par1, 0);
    chk({tag, "_flags"}, 0, wf0, 0);    chk({tag, "_flags"}, 1, wf1, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ch = '0; lane_a = '0; lane_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_chk("reset");
    rst = 1'b0;
    step(-1);
    en = 1'b1;
    step(-1);

    // Three qualified events on channel 2, one per cycle.
    in_valid = 1'b1; in_ch = 2'd2; lane_a = '1; lane_b = '0;
    repeat (3) step(1);
    in_valid = 1'b0;
    step(-1);

    // 32 events on channel 0 cross the all-ones boundary.
    in_ch = 2'd0; in_valid = 1'b1;
    repeat (32) step(1);
    in_valid = 1'b0;
    repeat (2) step(-1);
    chk("flags_after_wrap", 0, wf0, 3'b001);
    chk("flags_after_wrap", 1, wf1, 3'b001);

    // Lane 3 uncovered, then covered; then an out-of-range channel.
    in_valid = 1'b1; in_ch = 2'd1; lane_a = 5'b10110; lane_b = 5'b00001;
    step(1);
    lane_b = 5'b01001;
    step(1);
    in_ch = 2'd3; lane_a = '1;
    step(1);
    in_valid = 1'b0;
    step(-1);

    // Backpressure, then drop enable to drain the held beat.
    out_ready = 1'b0; in_valid = 1'b1; in_ch = 2'd2; lane_a = '1;
    step(1);
    repeat (4) step(0);
    en = 1'b0; in_valid = 1'b0;
    step(0);
    chk("busy_drain", 0, busy0, 1); chk("busy_drain", 1, busy1, 1);
    out_ready = 1'b1;
    step(-1);
    chk("busy_idle", 0, busy0, 0);  chk("busy_idle", 1, busy1, 0);

    // Clear collides with an offered event while a beat is still pending.
    en = 1'b1;
    step(-1);
    in_valid = 1'b1; in_ch = 2'd2; lane_a = '1;
    step(1);
    clr = 1'b1; out_ready = 1'b0; in_ch = 2'd0;
    step(0);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(-1);
    chk("flags_after_clr", 0, wf0, 0); chk("flags_after_clr", 1, wf1, 0);
    in_valid = 1'b1; in_ch = 2'd2;
    step(1);
    in_valid = 1'b0;
    step(-1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      in_valid  = $urandom_range(0, 1);
      in_ch     = CW'($urandom_range(0, 3));
      lane_a    = L'($urandom);
      lane_b    = ($urandom_range(0, 1) != 0) ? ~lane_a : L'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(-1);
    end
    en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step(-1);

    // Asynchronous reset while a beat is pending.
    out_ready = 1'b0; in_valid = 1'b1; in_ch = 2'd1; lane_a = '1;
    step(1);
    in_valid = 1'b0;
    step(-1);
    chk("pending_before_rst", 0, ov0, 1); chk("pending_before_rst", 1, ov1, 1);
    rst = 1'b1;
    model_reset();
    #1;
    reset_chk("midrst");
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (2) step(-1);

    chk("queue_empty", 0, exp_q[0].size(), 0);
    chk("queue_empty", 1, exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
